fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the datapath width, the default reset PC and the queue-entry layout.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32 by construction.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between fetch and decode: power-of-two depth, wrapping
// pointers, synchronous flush. Storage is deliberately left unreset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {CW{1'b0}});
    assign head_data = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register presented straight to instruction memory,
// returned word enqueued the same cycle, redirect flushes and refetches.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    logic [XLEN-1:0] pc_r;
    logic            push_s;
    logic            pop_s;
    logic            valid_s;
    logic            full_s;
    logic            empty_s;
    fetch_entry_t    wr_entry_s;
    fetch_entry_t    head_s;

    // Handshake decode; a redirect cycle suppresses every handshake.
    always_comb begin
        valid_s = 1'b0;
        pop_s   = 1'b0;
        push_s  = 1'b0;
        if (redirect_valid) begin
            valid_s = 1'b0;
            pop_s   = 1'b0;
            push_s  = 1'b0;
        end else begin
            valid_s = !empty_s;
            pop_s   = !empty_s && out_ready;
            push_s  = !full_s || pop_s;
        end
    end

    assign wr_entry_s = '{pc: pc_r, instr: imem_instr};

    // Program counter: redirect target is forced word-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push_s) begin
            pc_r <= pc_next(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (wr_entry_s),
        .full      (full_s),
        .empty     (empty_s),
        .head_data (head_s)
    );

    assign imem_addr = pc_r;
    assign out_valid = valid_s;
    assign out_instr = head_s.instr;
    assign out_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboard of expected {pc, instr}
// entries, compared as decode accepts them.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr, imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr, out_pc;

    logic [31:0] imem2_addr, imem2_instr;
    logic        redirect2_valid = 1'b0;
    logic [31:0] redirect2_pc = 32'h0;
    logic        out2_valid;
    logic        out2_ready = 1'b1;
    logic [31:0] out2_instr, out2_pc;

    int total = 0;
    int bad = 0;
    fetch_entry_t exp_q[$];
    fetch_entry_t e;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_instr  = mem_word(imem_addr);
    assign imem2_instr = mem_word(imem2_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(imem2_addr), .imem_instr(imem2_instr),
        .redirect_valid(redirect2_valid), .redirect_pc(redirect2_pc),
        .out_valid(out2_valid), .out_ready(out2_ready),
        .out_instr(out2_instr), .out_pc(out2_pc)
    );

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: a, instr: mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = rdy;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset: out_valid=%b imem_addr=%h, want 0 / 00000000", out_valid, imem_addr);
        end
        total++;
        if (out2_valid !== 1'b0 || imem2_addr !== 32'hFFFF_FFF8) begin
            bad++;
            $display("FAIL reset_pc_param: out_valid=%b imem_addr=%h, want 0 / fffffff8", out2_valid, imem2_addr);
        end
    endtask

    task automatic test_stream();
        expect_seq(32'h0, 8);
        do_reset(1'b1);
        @(negedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL stream_valid: cycle %0d out_valid=%b, want 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL stream_data: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin
                bad++;
                $display("FAIL stall_head: cycle %0d valid=%b pc=%h instr=%h, want 1/00000000/%h",
                         i, out_valid, out_pc, out_instr, mem_word(32'h0));
            end
            if (i >= 3) begin
                total++;
                if (imem_addr !== 32'h10) begin
                    bad++;
                    $display("FAIL stall_addr: cycle %0d imem_addr=%h want 00000010", i, imem_addr);
                end
            end
        end
        expect_seq(32'h0, 6);
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL drain_valid: cycle %0d out_valid=%b, want 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL drain_data: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0082;
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_valid: out_valid=%b want 0", out_valid);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_addr !== 32'h80 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL redirect_pc: imem_addr=%h valid=%b want 00000080/0", imem_addr, out_valid);
        end
        expect_seq(32'h80, 3);
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL redirect_out_valid: cycle %0d out_valid=%b want 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL redirect_data: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_full_pushpop();
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (imem_addr !== 32'h10) begin
            bad++;
            $display("FAIL full_addr: imem_addr=%h want 00000010", imem_addr);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL full_head: valid=%b pc=%h want 1/00000000", out_valid, out_pc);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (imem_addr !== 32'h14 || out_pc !== 32'h4) begin
                bad++;
                $display("FAIL full_hold: cycle %0d imem_addr=%h pc=%h want 00000014/00000004",
                         i, imem_addr, out_pc);
            end
            @(negedge clk);
        end
        expect_seq(32'h4, 5);
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL full_drain_valid: cycle %0d out_valid=%b want 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL full_drain_data: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        expect_seq(32'hFFFF_FFF8, 4);
        do_reset(1'b1);
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out2_valid !== 1'b1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL wrap_valid: cycle %0d out_valid=%b want 1", i, out2_valid);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (out2_pc !== e.pc || out2_instr !== e.instr) begin
                    bad++;
                    $display("FAIL wrap_data: got %h/%h want %h/%h", out2_pc, out2_instr, e.pc, e.instr);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1 || imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL mid_pre: valid=%b imem_addr=%h want 1/00000008", out_valid, imem_addr);
        end
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0400;
        #1;
        total++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL mid_async: valid=%b imem_addr=%h want 0/00000000", out_valid, imem_addr);
        end
        @(negedge clk); #1;
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL mid_hold: imem_addr=%h want 00000000", imem_addr);
        end
        expect_seq(32'h0, 3);
        rst = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || exp_q.size() == 0) begin
                bad++;
                $display("FAIL mid_refetch_valid: cycle %0d out_valid=%b want 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL mid_refetch_data: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr);
                end
            end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_full_pushpop();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
